// File: rtl/timer_ctrl_pkg.sv
// Shared state encoding and helpers for the timer controller.
// ST_CHECK exists only when TIMER_CTRL_ALARM_EN is defined.
package timer_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_RESP   = 2'd2
`ifdef TIMER_CTRL_ALARM_EN
    ,
    ST_CHECK  = 2'd3
`endif
  } state_t;

  // Increment a requester index modulo n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 32'sd1 >= n) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/timer_rr_arb.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Purely combinational; ptr is owned by timer_ctrl.
module timer_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  // Scan from ptr upwards; the first hit wins.
  always_comb begin
    logic             found_s;
    logic [IDX_W-1:0] idx_s;
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found_s && req[idx_s]) begin
        found_s      = 1'b1;
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: owns TIMER_ENABLE and shares the core snapshot port round-robin.
// Optional alarm compare: define TIMER_CTRL_ALARM_EN.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_set,
  input  logic                en_clr,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                busy,
  output logic                TIMER_ENABLE,
  output logic                TIMER_SAMPLE,
  input  logic [2*DATA_W-1:0] TIMER_VALUE
`ifdef TIMER_CTRL_ALARM_EN
  ,
  input  logic                alarm_wr,
  input  logic [2*DATA_W-1:0] alarm_val,
  input  logic                alarm_clr,
  output logic                alarm_irq
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic [N_REQ-1:0] gnt_oh_r;
  logic [N_REQ-1:0] arb_grant_s;
  logic [IDX_W-1:0] arb_idx_s;

`ifdef TIMER_CTRL_ALARM_EN
  logic [2*DATA_W-1:0] cmp_r;
  logic                armed_r;
  logic                bg_r;
  logic                hit_s;
`endif

  timer_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s)
  );

  // The core refreshes TIMER_VALUE on the same edge that raises rsp_valid,
  // so the snapshot is passed through under the registered valid.
  assign rsp_data = (|rsp_valid) ? TIMER_VALUE : '0;

  // Counter enable register; clear dominates set.
  always_ff @(posedge clk) begin
    if (rst) begin
      TIMER_ENABLE <= 1'b0;
    end else if (en_clr) begin
      TIMER_ENABLE <= 1'b0;
    end else if (en_set) begin
      TIMER_ENABLE <= 1'b1;
    end
  end

  // Snapshot sequencer with registered strobe, response and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      gnt_idx_r    <= '0;
      gnt_oh_r     <= '0;
      rsp_valid    <= '0;
      TIMER_SAMPLE <= 1'b0;
      busy         <= 1'b0;
`ifdef TIMER_CTRL_ALARM_EN
      bg_r         <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid <= '0;
          if (|req) begin
            gnt_idx_r    <= arb_idx_s;
            gnt_oh_r     <= arb_grant_s;
            TIMER_SAMPLE <= 1'b1;
            busy         <= 1'b1;
            state_r      <= ST_SAMPLE;
`ifdef TIMER_CTRL_ALARM_EN
            bg_r         <= 1'b0;
          end else if (armed_r) begin
            TIMER_SAMPLE <= 1'b1;
            busy         <= 1'b1;
            bg_r         <= 1'b1;
            state_r      <= ST_SAMPLE;
`endif
          end else begin
            TIMER_SAMPLE <= 1'b0;
            busy         <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          TIMER_SAMPLE <= 1'b0;
`ifdef TIMER_CTRL_ALARM_EN
          if (bg_r) begin
            state_r <= ST_CHECK;
          end else
`endif
          begin
            rsp_valid <= gnt_oh_r;
            state_r   <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid <= '0;
          ptr_r     <= IDX_W'(wrap_inc(int'(gnt_idx_r), N_REQ));
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
`ifdef TIMER_CTRL_ALARM_EN
        ST_CHECK: begin
          busy    <= 1'b0;
          bg_r    <= 1'b0;
          state_r <= ST_IDLE;
        end
`endif
        default: begin
          rsp_valid    <= '0;
          TIMER_SAMPLE <= 1'b0;
          busy         <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TIMER_CTRL_ALARM_EN
  assign hit_s = (state_r == ST_CHECK) && armed_r && (TIMER_VALUE >= cmp_r);

  // Alarm compare register, arm flag and sticky interrupt; a hit beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_r     <= '0;
      armed_r   <= 1'b0;
      alarm_irq <= 1'b0;
    end else begin
      if (alarm_wr) begin
        cmp_r   <= alarm_val;
        armed_r <= 1'b1;
      end else if (hit_s) begin
        armed_r <= 1'b0;
      end
      if (hit_s) begin
        alarm_irq <= 1'b1;
      end else if (alarm_clr) begin
        alarm_irq <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with a behavioural 64-bit timer core.
// Alarm scenario is compiled only with TIMER_CTRL_ALARM_EN.
module tb_timer_ctrl;

  logic        clk;
  logic        rst;
  logic        en_set;
  logic        en_clr;
  logic [3:0]  req;
  logic [3:0]  rsp_valid;
  logic [63:0] rsp_data;
  logic        busy;
  logic        TIMER_ENABLE;
  logic        TIMER_SAMPLE;
  logic [63:0] count_q = 64'h0000_0000_FFFF_FFF0;
  logic [63:0] snap_q  = 64'h0;
`ifdef TIMER_CTRL_ALARM_EN
  logic        alarm_wr;
  logic [63:0] alarm_val;
  logic        alarm_clr;
  logic        alarm_irq;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  timer_ctrl #(.DATA_W(32), .N_REQ(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_set       (en_set),
    .en_clr       (en_clr),
    .req          (req),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .TIMER_ENABLE (TIMER_ENABLE),
    .TIMER_SAMPLE (TIMER_SAMPLE),
    .TIMER_VALUE  (snap_q)
`ifdef TIMER_CTRL_ALARM_EN
    ,
    .alarm_wr     (alarm_wr),
    .alarm_val    (alarm_val),
    .alarm_clr    (alarm_clr),
    .alarm_irq    (alarm_irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer core: free-running count while enabled, snapshot on strobe.
  always @(posedge clk) begin
    if (TIMER_ENABLE) count_q <= count_q + 64'd1;
    if (TIMER_SAMPLE) snap_q <= count_q;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en_set = 1'b0; en_clr = 1'b0; req = 4'b0000;
`ifdef TIMER_CTRL_ALARM_EN
    alarm_wr = 1'b0; alarm_val = 64'd0; alarm_clr = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
  endtask

  // Reference arbitration rule: first requester at or after p, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, expected 0000", rsp_valid); end
    n_cmp++; if (rsp_data !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %h, expected 0", rsp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_cmp++; if (TIMER_ENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b, expected 0", TIMER_ENABLE); end
    n_cmp++; if (TIMER_SAMPLE !== 1'b0) begin n_fail++; $display("FAIL reset_sample: got %b, expected 0", TIMER_SAMPLE); end
  endtask

  task automatic test_single();
    logic [63:0] snap;
    en_set = 1'b1; step(); en_set = 1'b0;
    n_cmp++; if (TIMER_ENABLE !== 1'b1) begin n_fail++; $display("FAIL single_enable: got %b, expected 1", TIMER_ENABLE); end
    req = 4'b0001;
    step();
    snap = count_q;
    n_cmp++; if (TIMER_SAMPLE !== 1'b1) begin n_fail++; $display("FAIL single_sample_t1: got %b, expected 1", TIMER_SAMPLE); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t1: got %b, expected 1", busy); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_t1: got %b, expected 0000", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_t2: got %b, expected 0001", rsp_valid); end
    n_cmp++; if (rsp_data !== snap) begin n_fail++; $display("FAIL single_data_t2: got %h, expected %h", rsp_data, snap); end
    n_cmp++; if (TIMER_SAMPLE !== 1'b0) begin n_fail++; $display("FAIL single_sample_t2: got %b, expected 0", TIMER_SAMPLE); end
    req = 4'b0000;
    step();
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_t3: got %b, expected 0000", rsp_valid); end
    n_cmp++; if (rsp_data !== 64'd0) begin n_fail++; $display("FAIL single_data_t3: got %h, expected 0", rsp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_t3: got %b, expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  pend;
    logic [3:0]  exp_rv;
    logic [63:0] snap;
    do_reset();
    en_set = 1'b1; step(); en_set = 1'b0;
    pend = 4'b1111; req = pend;
    snap = 64'd0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 3 == 1) snap = count_q;
      exp_rv = (k % 3 == 2) ? (4'b0001 << (k / 3)) : 4'b0000;
      n_cmp++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rr_rsp_valid k=%0d: got %b, expected %b", k, rsp_valid, exp_rv); end
      if (exp_rv != 4'b0000) begin
        n_cmp++; if (rsp_data !== snap) begin n_fail++; $display("FAIL rr_rsp_data k=%0d: got %h, expected %h", k, rsp_data, snap); end
      end
      if (k % 3 == 0) pend = pend & ~(4'b0001 << (k / 3 - 1));
      req = pend;
    end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_wrap();
    int         seq [4] = '{3, 0, 1, 0};
    int         n;
    logic [3:0] last;
    req = 4'b0100;
    step(); step();
    n_cmp++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup: got %b, expected 0100", rsp_valid); end
    step();
    req = 4'b1001;
    n = 0; last = 4'b0000;
    for (int k = 0; k < 20 && n < 4; k++) begin
      step();
      if (last != 4'b0000) begin
        if (n == 2) req = req | 4'b0010;
        else        req = req & ~last;
      end
      last = rsp_valid;
      if (rsp_valid != 4'b0000) begin
        n_cmp++; if (rsp_valid !== (4'b0001 << seq[n])) begin n_fail++; $display("FAIL wrap_grant %0d: got %b, expected %b", n, rsp_valid, 4'b0001 << seq[n]); end
        n++;
      end
    end
    n_cmp++; if (n != 4) begin n_fail++; $display("FAIL wrap_timeout: got %0d responses, expected 4", n); end
    step(); req = 4'b0000; step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_enable_freeze();
    logic [63:0] frozen;
    en_set = 1'b1; step(); en_set = 1'b0;
    n_cmp++; if (TIMER_ENABLE !== 1'b1) begin n_fail++; $display("FAIL freeze_pre_enable: got %b, expected 1", TIMER_ENABLE); end
    en_set = 1'b1; en_clr = 1'b1; step(); en_set = 1'b0; en_clr = 1'b0;
    n_cmp++; if (TIMER_ENABLE !== 1'b0) begin n_fail++; $display("FAIL freeze_clr_wins: got %b, expected 0", TIMER_ENABLE); end
    frozen = count_q;
    for (int s = 0; s < 2; s++) begin
      req = 4'b0001;
      step(); step();
      n_cmp++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL freeze_rsp%0d: got %b, expected 0001", s, rsp_valid); end
      n_cmp++; if (rsp_data !== frozen) begin n_fail++; $display("FAIL freeze_data%0d: got %h, expected %h", s, rsp_data, frozen); end
      step(); req = 4'b0000; step();
    end
  endtask

  task automatic test_reset_mid();
    en_set = 1'b1; step(); en_set = 1'b0;
    req = 4'b0100;
    step();
    n_cmp++; if (TIMER_SAMPLE !== 1'b1) begin n_fail++; $display("FAIL rstmid_sample: got %b, expected 1", TIMER_SAMPLE); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rsp: got %b, expected 0000", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    n_cmp++; if (TIMER_ENABLE !== 1'b0) begin n_fail++; $display("FAIL rstmid_enable: got %b, expected 0", TIMER_ENABLE); end
    step(); step();
    n_cmp++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL rstmid_rearb: got %b, expected 0100", rsp_valid); end
    step(); req = 4'b0000; step();
  endtask

  task automatic test_random();
    int          ptr, g, next_free, smp_at, rsp_at;
    logic [3:0]  pend, last_rsp, exp_rv;
    logic [63:0] exp_data, exp_d;
    logic        exp_en;
    do_reset();
    ptr = 0; g = 0; next_free = 0; smp_at = -1; rsp_at = -1;
    pend = 4'b0000; last_rsp = 4'b0000; exp_en = 1'b0; exp_data = 64'd0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (c == smp_at) exp_data = count_q;
      exp_rv = (c == rsp_at) ? (4'b0001 << g) : 4'b0000;
      exp_d  = (c == rsp_at) ? exp_data : 64'd0;
      n_cmp++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_rsp_valid c=%0d: got %b, expected %b", c, rsp_valid, exp_rv); end
      n_cmp++; if (rsp_data !== exp_d) begin n_fail++; $display("FAIL rand_rsp_data c=%0d: got %h, expected %h", c, rsp_data, exp_d); end
      n_cmp++; if (TIMER_SAMPLE !== (c == smp_at)) begin n_fail++; $display("FAIL rand_sample c=%0d: got %b, expected %b", c, TIMER_SAMPLE, c == smp_at); end
      n_cmp++; if (busy !== (c == smp_at || c == rsp_at)) begin n_fail++; $display("FAIL rand_busy c=%0d: got %b, expected %b", c, busy, c == smp_at || c == rsp_at); end
      n_cmp++; if (TIMER_ENABLE !== exp_en) begin n_fail++; $display("FAIL rand_enable c=%0d: got %b, expected %b", c, TIMER_ENABLE, exp_en); end
      pend = pend & ~last_rsp;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) pend[i] = 1'b1;
      end
      last_rsp = exp_rv;
      req    = pend;
      en_set = ($urandom_range(7) == 0);
      en_clr = ($urandom_range(15) == 0);
      exp_en = en_clr ? 1'b0 : (en_set ? 1'b1 : exp_en);
      if (c >= next_free && pend != 4'b0000) begin
        g = pick(pend, ptr);
        smp_at = c + 1; rsp_at = c + 2; next_free = c + 3;
        ptr = (g + 1) % 4;
      end
    end
    req = 4'b0000; en_set = 1'b0; en_clr = 1'b0;
    step(); step(); step();
  endtask

`ifdef TIMER_CTRL_ALARM_EN
  task automatic test_alarm();
    logic [63:0] target;
    logic        seen;
    do_reset();
    en_set = 1'b1; step(); en_set = 1'b0;
    target = count_q + 64'd30;
    alarm_val = target; alarm_wr = 1'b1; step(); alarm_wr = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      step();
      if (count_q < target) begin
        n_cmp++; if (alarm_irq !== 1'b0) begin n_fail++; $display("FAIL alarm_early: got %b, expected 0 at count %h", alarm_irq, count_q); end
      end else if (alarm_irq === 1'b1) begin
        seen = 1'b1;
        n_cmp++; if (count_q - target > 64'd5) begin n_fail++; $display("FAIL alarm_latency: got %0d cycles, expected <= 5", count_q - target); end
      end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL alarm_timeout: got irq %b, expected 1", alarm_irq); end
    alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
    n_cmp++; if (alarm_irq !== 1'b0) begin n_fail++; $display("FAIL alarm_clr: got %b, expected 0", alarm_irq); end
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++; if (alarm_irq !== 1'b0) begin n_fail++; $display("FAIL alarm_refire: got %b, expected 0", alarm_irq); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_enable_freeze();
    test_reset_mid();
    test_random();
`ifdef TIMER_CTRL_ALARM_EN
    test_alarm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
